// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and link defaults common to RX and TX.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_RECOVER = 3'd4
    } uart_rx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; resets to 1 (idle line level).
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic baud_clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw line through the synchronizer chain; reset to idle-high.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start-bit qualification, LSB-first data capture, stop-bit
// check, and a valid/ack holding register with framing-error and overrun reporting.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 baud_clk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 rx_overrun,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Mid start bit is half a bit after the falling edge; mid data/stop bits are a full bit apart.
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_t       state_r;
    logic [TICK_W-1:0]    tick_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 busy_r;
    logic                 frame_error_r;
    logic                 deliver_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 rx_overrun_r;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .baud_clk (baud_clk),
        .reset_n  (reset_n),
        .d        (rx),
        .q        (rx_s)
    );

    // Frame FSM: walks each bit period on the tick counter and flags delivery or framing error.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= S_IDLE;
            tick_r        <= '0;
            bit_idx_r     <= '0;
            shift_r       <= '0;
            busy_r        <= 1'b0;
            frame_error_r <= 1'b0;
            deliver_r     <= 1'b0;
        end else begin
            frame_error_r <= 1'b0;
            deliver_r     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    tick_r <= '0;
                    if (!rx_s) begin
                        state_r <= S_START;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick_r == TICK_MID) begin
                        tick_r <= '0;
                        if (rx_s) begin
                            // Line went back high: a glitch, not a start bit.
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r   <= S_DATA;
                            bit_idx_r <= '0;
                        end
                    end else begin
                        tick_r <= tick_r + TICK_W'(1);
                    end
                end
                S_DATA: begin
                    if (tick_r == TICK_LAST) begin
                        tick_r             <= '0;
                        shift_r[bit_idx_r] <= rx_s;
                        if (bit_idx_r == IDX_LAST) begin
                            state_r <= S_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                        end
                    end else begin
                        tick_r <= tick_r + TICK_W'(1);
                    end
                end
                S_STOP: begin
                    if (tick_r == TICK_LAST) begin
                        tick_r <= '0;
                        busy_r <= 1'b0;
                        if (rx_s) begin
                            // Returning to IDLE mid stop bit lets a back-to-back frame be caught.
                            state_r   <= S_IDLE;
                            deliver_r <= 1'b1;
                        end else begin
                            state_r       <= S_RECOVER;
                            frame_error_r <= 1'b1;
                        end
                    end else begin
                        tick_r <= tick_r + TICK_W'(1);
                    end
                end
                S_RECOVER: begin
                    // A held-low break must end before a new start bit can be recognised.
                    tick_r <= '0;
                    if (rx_s) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_RECOVER;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    tick_r  <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Consumer handshake: hold the byte until acked, record drops while the holder is full.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else if (deliver_r) begin
            if (!rx_valid_r || rx_ack) begin
                rx_data_r  <= shift_r;
                rx_valid_r <= 1'b1;
            end else begin
                rx_overrun_r <= 1'b1;
            end
        end else if (rx_ack && rx_valid_r) begin
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else begin
            rx_valid_r   <= rx_valid_r;
            rx_overrun_r <= rx_overrun_r;
        end
    end

    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign frame_error = frame_error_r;
    assign rx_overrun  = rx_overrun_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 8N1, OVERSAMPLE=16.
module tb_uart_receiver;

    localparam int OS = 16;

    logic       baud_clk;
    logic       reset_n;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       rx_overrun;
    logic       busy;

    int checks;
    int errors;
    int fe_count;

    uart_receiver #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (2)
    ) dut (
        .baud_clk    (baud_clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .rx_overrun  (rx_overrun),
        .busy        (busy)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    // Count every cycle in which frame_error is high, sampled away from the active edge.
    initial fe_count = 0;
    always @(negedge baud_clk) begin
        if (frame_error === 1'b1) fe_count = fe_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge baud_clk);
    endtask

    // Start bit plus LSB-first data bits.
    task automatic send_head(input logic [7:0] data);
        rx = 1'b0;
        wait_cycles(OS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_cycles(OS);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        send_head(data);
        rx = stop_bit;
        wait_cycles(OS);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        wait_cycles(1);
        rx_ack = 1'b0;
    endtask

    initial begin
        int   fe_base;
        int   busy_hold;
        logic seen;
        int   waited;

        checks  = 0;
        errors  = 0;
        rx      = 1'b1;
        rx_ack  = 1'b0;
        reset_n = 1'b0;
        wait_cycles(3);

        // Reset values
        check("rst_valid",   {31'd0, rx_valid},    32'd0);
        check("rst_data",    {24'd0, rx_data},     32'd0);
        check("rst_ferr",    {31'd0, frame_error}, 32'd0);
        check("rst_overrun", {31'd0, rx_overrun},  32'd0);
        check("rst_busy",    {31'd0, busy},        32'd0);
        reset_n = 1'b1;
        wait_cycles(4);

        // Clean 0xA5
        fe_base = fe_count;
        send_frame(8'hA5, 1'b1);
        wait_cycles(2 * OS);
        check("a5_valid", {31'd0, rx_valid}, 32'd1);
        check("a5_data",  {24'd0, rx_data},  32'h0000_00A5);
        check("a5_ferr",  fe_count - fe_base, 32'd0);
        check("a5_busy",  {31'd0, busy},     32'd0);
        ack_pulse();
        check("a5_ack_valid", {31'd0, rx_valid}, 32'd0);

        // 4-cycle glitch on idle line
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge baud_clk);
            if (busy === 1'b1) seen = 1'b1;
        end
        check("glitch_busy_seen", {31'd0, seen},     32'd1);
        check("glitch_busy_end",  {31'd0, busy},     32'd0);
        check("glitch_valid",     {31'd0, rx_valid}, 32'd0);

        // 0x3C with bad stop bit, line held low for 40 bit-times in total
        fe_base = fe_count;
        send_head(8'h3C);
        rx = 1'b0;
        wait_cycles(OS);
        busy_hold = 0;
        for (int i = 0; i < 39 * OS; i++) begin
            @(negedge baud_clk);
            if (busy === 1'b1) busy_hold = busy_hold + 1;
        end
        check("brk_ferr_pulses", fe_count - fe_base, 32'd1);
        check("brk_valid",       {31'd0, rx_valid}, 32'd0);
        check("brk_no_retrig",   busy_hold,         32'd0);
        rx = 1'b1;
        wait_cycles(2 * OS);
        send_frame(8'h11, 1'b1);
        wait_cycles(OS);
        check("after_brk_valid", {31'd0, rx_valid}, 32'd1);
        check("after_brk_data",  {24'd0, rx_data},  32'h0000_0011);
        check("after_brk_ferr",  fe_count - fe_base, 32'd1);
        ack_pulse();

        // Back-to-back 0x01, 0x02 without ack
        wait_cycles(OS);
        send_frame(8'h01, 1'b1);
        check("b2b_first_valid",   {31'd0, rx_valid},   32'd1);
        check("b2b_first_data",    {24'd0, rx_data},    32'h0000_0001);
        check("b2b_first_overrun", {31'd0, rx_overrun}, 32'd0);
        send_frame(8'h02, 1'b1);
        check("b2b_second_data",    {24'd0, rx_data},    32'h0000_0001);
        check("b2b_second_overrun", {31'd0, rx_overrun}, 32'd1);
        check("b2b_second_valid",   {31'd0, rx_valid},   32'd1);
        ack_pulse();
        check("b2b_ack_valid",   {31'd0, rx_valid},   32'd0);
        check("b2b_ack_overrun", {31'd0, rx_overrun}, 32'd0);

        // Ack landing in the exact delivery cycle of a second byte
        wait_cycles(OS);
        send_frame(8'h01, 1'b1);
        check("dack_first_valid", {31'd0, rx_valid}, 32'd1);
        send_head(8'h02);
        rx = 1'b1;
        waited = 0;
        while (busy === 1'b1 && waited < 2 * OS) begin
            @(negedge baud_clk);
            waited = waited + 1;
        end
        check("dack_stop_seen", {31'd0, busy}, 32'd0);
        // Stop sample was taken on the edge just passed; the next edge is the delivery cycle.
        ack_pulse();
        wait_cycles(OS);
        check("dack_data",    {24'd0, rx_data},    32'h0000_0002);
        check("dack_valid",   {31'd0, rx_valid},   32'd1);
        check("dack_overrun", {31'd0, rx_overrun}, 32'd0);

        // Reset during data bit 4 of 0xFF, then 0x5A
        rx = 1'b0;
        wait_cycles(OS);
        rx = 1'b1;
        wait_cycles(4 * OS + 5);
        reset_n = 1'b0;
        wait_cycles(3);
        check("mid_rst_valid", {31'd0, rx_valid},   32'd0);
        check("mid_rst_data",  {24'd0, rx_data},    32'd0);
        check("mid_rst_busy",  {31'd0, busy},       32'd0);
        check("mid_rst_ovr",   {31'd0, rx_overrun}, 32'd0);
        reset_n = 1'b1;
        wait_cycles(OS - 8 + 4 * OS);
        wait_cycles(2 * OS);
        check("post_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("post_rst_busy",  {31'd0, busy},     32'd0);
        fe_base = fe_count;
        send_frame(8'h5A, 1'b1);
        wait_cycles(OS);
        check("rst_5a_valid", {31'd0, rx_valid}, 32'd1);
        check("rst_5a_data",  {24'd0, rx_data},  32'h0000_005A);
        check("rst_5a_ferr",  fe_count - fe_base, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
